// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - Moore main/side traffic-light sequencer with pedestrian WALK phase.
// Phase durations are counted in upstream tick pulses; the state register is exported for display.
module traffic_light_fsm #(
  parameter int GREEN_TICKS   = 8,
  parameter int YELLOW_TICKS  = 2,
  parameter int ALL_RED_TICKS = 1,
  parameter int WALK_TICKS    = 4,
  parameter int TW            = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALL_RED_1   = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALL_RED_2   = 3'd5,
    S_WALK        = 3'd6,
    S_ILLEGAL     = 3'd7
  } state_t;

  localparam logic [TW-1:0] LD_GREEN   = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] LD_YELLOW  = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] LD_ALL_RED = TW'(ALL_RED_TICKS - 1);
  localparam logic [TW-1:0] LD_WALK    = TW'(WALK_TICKS - 1);

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_ped_pending;
  logic          r_ped_prev;
  logic          r_ped_ack;

  state_t        w_state_nxt;
  state_t        w_succ;
  logic [TW-1:0] w_timer_nxt;
  logic          w_ped_pending_nxt;
  logic          w_enter_walk;
  logic          w_rise;

  function automatic logic [TW-1:0] load_for(input state_t s);
    case (s)
      S_MAIN_GREEN, S_SIDE_GREEN:   load_for = LD_GREEN;
      S_MAIN_YELLOW, S_SIDE_YELLOW: load_for = LD_YELLOW;
      S_WALK:                       load_for = LD_WALK;
      default:                      load_for = LD_ALL_RED;
    endcase
  endfunction

  assign w_rise = ped_req & ~r_ped_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_ALL_RED_2;
      r_timer       <= LD_ALL_RED;
      r_ped_pending <= 1'b0;
      r_ped_prev    <= 1'b0;
      r_ped_ack     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_ped_pending <= w_ped_pending_nxt;
      r_ped_prev    <= ped_req;
      r_ped_ack     <= w_enter_walk;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_ped_pending_nxt = r_ped_pending;
    w_enter_walk      = 1'b0;
    case (r_state)
      S_MAIN_GREEN:  w_succ = S_MAIN_YELLOW;
      S_MAIN_YELLOW: w_succ = S_ALL_RED_1;
      S_ALL_RED_1:   w_succ = S_SIDE_GREEN;
      S_SIDE_GREEN:  w_succ = S_SIDE_YELLOW;
      S_SIDE_YELLOW: w_succ = S_ALL_RED_2;
      S_ALL_RED_2:   w_succ = r_ped_pending ? S_WALK : S_MAIN_GREEN;
      S_WALK:        w_succ = S_MAIN_GREEN;
      default:       w_succ = S_ALL_RED_2;
    endcase

    // An illegal code recovers on the very next clock, independent of tick.
    if (r_state == S_ILLEGAL) begin
      w_state_nxt = S_ALL_RED_2;
      w_timer_nxt = LD_ALL_RED;
    end else if (tick) begin
      if (r_timer == '0) begin
        w_state_nxt = w_succ;
        w_timer_nxt = load_for(w_succ);
      end else begin
        w_timer_nxt = r_timer - TW'(1);
      end
    end

    w_enter_walk = (w_state_nxt == S_WALK) && (r_state != S_WALK);

    // Entering WALK consumes the request, even if a new edge arrives on the same clock.
    if (w_enter_walk) begin
      w_ped_pending_nxt = 1'b0;
    end else if (w_rise && (r_state != S_WALK)) begin
      w_ped_pending_nxt = 1'b1;
    end
  end

  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    walk       = 1'b0;
    case (r_state)
      S_MAIN_GREEN:  main_light = LIGHT_GREEN;
      S_MAIN_YELLOW: main_light = LIGHT_YELLOW;
      S_SIDE_GREEN:  side_light = LIGHT_GREEN;
      S_SIDE_YELLOW: side_light = LIGHT_YELLOW;
      S_WALK:        walk       = 1'b1;
      default:       ;
    endcase
  end

  assign ped_ack = r_ped_ack;
  assign state   = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - table-driven, scoreboarded bench for traffic_light_fsm.
module tb_traffic_light_fsm;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state;

  traffic_light_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    int         ticks;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    bit         ped;
    bit         frz;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    logic       ack;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;
  int   ped_hold;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t {st,main,side,walk,ack} actual=%b required=%b", name, $time, act, req);
    end
  endtask

  task automatic do_cycle(input logic t, input string name);
    exp_t e;
    @(negedge clock);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, {state, main_light, side_light, walk, ped_ack}, e);
    end
    tick    = t;
    ped_req = (ped_hold > 0);
    if (ped_hold > 0) ped_hold--;
  endtask

  task automatic add(input logic [2:0] st, input int ticks, input logic [2:0] ml,
                     input logic [2:0] sl, input logic wk, input bit ped, input bit frz);
    vec_t v;
    v.st = st; v.ticks = ticks; v.ml = ml; v.sl = sl; v.wk = wk; v.ped = ped; v.frz = frz;
    tbl.push_back(v);
  endtask

  task automatic add_road_cycle(input bit ped_main, input bit ped_side, input bit frz_side);
    add(3'd0, 8, G, R, 1'b0, ped_main, 1'b0);
    add(3'd1, 2, Y, R, 1'b0, 1'b0, 1'b0);
    add(3'd2, 1, R, R, 1'b0, 1'b0, 1'b0);
    add(3'd3, 8, R, G, 1'b0, ped_side, frz_side);
    add(3'd4, 2, R, Y, 1'b0, 1'b0, 1'b0);
    add(3'd5, 1, R, R, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_phase(input vec_t v);
    exp_t  e;
    string nm;
    nm = $sformatf("phase_s%0d", v.st);
    if (v.ped) ped_hold = 1;
    for (int p = 0; p < v.ticks; p++) begin
      if (v.frz && p == 1) begin
        for (int k = 0; k < 50; k++) begin
          e = '{st: v.st, ml: v.ml, sl: v.sl, wk: v.wk, ack: 1'b0};
          sb_q.push_back(e);
          do_cycle(1'b0, "freeze");
        end
      end
      for (int c = 0; c < 6; c++) begin
        e = '{st: v.st, ml: v.ml, sl: v.sl, wk: v.wk, ack: (v.st == 3'd6 && p == 0 && c == 0)};
        sb_q.push_back(e);
        do_cycle(c == 5, nm);
      end
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) run_phase(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    ped_hold = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    ped_req  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {state, main_light, side_light, walk, ped_ack}, {3'd5, R, R, 1'b0, 1'b0});
    @(negedge clock);
    reset = 1'b1;

    // Full road cycle, then a single-clock press in MAIN_GREEN served after ALL_RED_2.
    add(3'd5, 1, R, R, 1'b0, 1'b0, 1'b0);
    add_road_cycle(1'b0, 1'b0, 1'b0);
    add_road_cycle(1'b1, 1'b0, 1'b0);
    add(3'd6, 4, R, R, 1'b1, 1'b0, 1'b0);
    run_table();

    // Button held 200 clocks: one WALK and one ack only.
    ped_hold = 200;
    add_road_cycle(1'b0, 1'b0, 1'b0);
    add(3'd6, 4, R, R, 1'b1, 1'b0, 1'b0);
    add_road_cycle(1'b0, 1'b0, 1'b0);
    run_table();

    // Press during WALK is ignored.
    add_road_cycle(1'b1, 1'b0, 1'b0);
    add(3'd6, 4, R, R, 1'b1, 1'b1, 1'b0);
    add_road_cycle(1'b0, 1'b0, 1'b0);
    add(3'd0, 1, G, R, 1'b0, 1'b0, 1'b0);
    run_table();

    // Freeze in SIDE_GREEN with a press pending, then into SIDE_YELLOW.
    add(3'd0, 7, G, R, 1'b0, 1'b0, 1'b0);
    add(3'd1, 2, Y, R, 1'b0, 1'b0, 1'b0);
    add(3'd2, 1, R, R, 1'b0, 1'b0, 1'b0);
    add(3'd3, 8, R, G, 1'b0, 1'b1, 1'b1);
    add(3'd4, 1, R, Y, 1'b0, 1'b0, 1'b0);
    run_table();

    // Asynchronous reset mid-SIDE_YELLOW, away from any clock edge.
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset", {state, main_light, side_light, walk, ped_ack}, {3'd5, R, R, 1'b0, 1'b0});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick  = 1'b0;

    // The lost request must not produce a WALK.
    add(3'd5, 1, R, R, 1'b0, 1'b0, 1'b0);
    add_road_cycle(1'b0, 1'b0, 1'b0);
    add(3'd0, 1, G, R, 1'b0, 1'b0, 1'b0);
    run_table();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain leftover=%0d required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
